// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock. Round keys are fetched from an
// external key store through rk_idx/rk. Finished blocks are held until out_ready.
module mixColumns (
  input  logic [127:0] state,
  output logic [127:0] mixed
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
            xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
  endfunction

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++)
      mixed[127-32*c -: 32] = mix_col(state[127-32*c -: 32]);
  end
endmodule

module aes_enc_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       st;
  logic [3:0]   cnt;
  logic [127:0] state_reg;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] rnd_next;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as the GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) inv = gf_mul(gf_mul(inv, inv), b);
    inv = gf_mul(inv, inv);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-32*c-8*rw -: 8] = s[127-32*((c+rw)%4)-8*rw -: 8];
    return r;
  endfunction

  assign sr = shift_rows(sub_bytes(state_reg));

  mixColumns u_mix (
    .state (sr),
    .mixed (mc)
  );

  // The final round skips MixColumns.
  assign rnd_next = ((cnt == 4'd10) ? sr : mc) ^ rk;
  assign in_ready = (st == IDLE) || ((st == DONE) && out_ready);
  assign rk_idx   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cnt       <= 4'd0;
      state_reg <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ct        <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            state_reg <= pt ^ rk;
            cnt       <= 4'd1;
            busy      <= 1'b1;
            st        <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= rnd_next;
          if (cnt == 4'd10) begin
            cnt       <= 4'd0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            ct        <= rnd_next;
            st        <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ct        <= '0;
            if (in_valid) begin
              state_reg <= pt ^ rk;
              cnt       <= 4'd1;
              busy      <= 1'b1;
              st        <= ROUND;
            end else begin
              st <= IDLE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_enc_ctrl.sv
// Directed bench for aes_enc_ctrl using FIPS-197 vectors and a combinational key store.
module tb_aes_enc_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic key_sel = 1'b0;

  logic [7:0]   sbox_t [256];
  logic [127:0] sched  [2][11];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rk = '0;
    if (rk_idx <= 4'd10) rk = sched[key_sel][rk_idx];
  end

  aes_enc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt        (pt),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct        (ct),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // S-box built from the log/antilog walk over generator 3.
  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] key, input int sel);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) sched[sel][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // Offers one block and waits (bounded) for out_valid; lat counts cycles after the accept edge.
  task automatic run_block(input logic ks, input logic [127:0] p, output int lat);
    int n;
    key_sel  = ks;
    pt       = p;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin tick; n++; end
    tick;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin tick; lat++; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pt = '0;
    tick; tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (ct !== 128'h0) begin bad++; $display("FAIL reset_ct got=%h want=0", ct); end
    total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL reset_rk_idx got=%0d want=0", rk_idx); end
    #3 rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_app_b;
    int lat;
    total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL idle_rk_idx got=%0d want=0", rk_idx); end
    run_block(1'b0, PT_B, lat);
    total++; if (lat != 10) begin bad++; $display("FAIL app_b_latency got=%0d want=10", lat); end
    total++; if (ct !== CT_B) begin bad++; $display("FAIL app_b_ct got=%h want=%h", ct, CT_B); end
    total++; if (busy !== 1'b0 || rk_idx !== 4'd0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL app_b_done_ctl got busy=%b rk_idx=%0d in_ready=%b want 0,0,0", busy, rk_idx, in_ready);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || ct !== 128'h0) begin
      bad++; $display("FAIL app_b_drain got out_valid=%b ct=%h want 0,0", out_valid, ct);
    end
  endtask

  task automatic test_app_c;
    int lat;
    run_block(1'b1, PT_C, lat);
    total++; if (lat != 10) begin bad++; $display("FAIL app_c_latency got=%0d want=10", lat); end
    total++; if (ct !== CT_C) begin bad++; $display("FAIL app_c_ct got=%h want=%h", ct, CT_C); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL app_c_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure;
    int lat;
    run_block(1'b0, PT_B, lat);
    for (int i = 0; i < 20; i++) begin
      tick;
      total++;
      if (out_valid !== 1'b1 || ct !== CT_B || in_ready !== 1'b0 || rk_idx !== 4'd0) begin
        bad++;
        $display("FAIL hold_%0d got out_valid=%b ct=%h in_ready=%b rk_idx=%0d want 1,%h,0,0",
                 i, out_valid, ct, in_ready, rk_idx, CT_B);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_in_ready got=%b want=1", in_ready); end
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL hold_release got out_valid=%b busy=%b want 0,0", out_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    int n, c1, c2;
    out_ready = 1'b1; in_valid = 1'b1; key_sel = 1'b0; pt = PT_B;
    tick;
    n = 0;
    while (!out_valid && n < 30) begin tick; n++; end
    c1 = cyc;
    total++; if (ct !== CT_B || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_ct got=%h want=%h", ct, CT_B); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_done_in_ready got=%b want=1", in_ready); end
    key_sel = 1'b1; pt = PT_C;
    tick;
    total++; if (out_valid !== 1'b0 || busy !== 1'b1 || rk_idx !== 4'd1) begin
      bad++; $display("FAIL b2b_second_accept got out_valid=%b busy=%b rk_idx=%0d want 0,1,1", out_valid, busy, rk_idx);
    end
    n = 0;
    while (!out_valid && n < 30) begin tick; n++; end
    c2 = cyc;
    total++; if (ct !== CT_C || out_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_ct got=%h want=%h", ct, CT_C); end
    total++; if (c2 - c1 != 11) begin bad++; $display("FAIL b2b_spacing got=%0d want=11", c2 - c1); end
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_idle got out_valid=%b in_ready=%b want 0,1", out_valid, in_ready);
    end
  endtask

  task automatic test_in_valid_toggle;
    out_ready = 1'b0; key_sel = 1'b1; pt = PT_C; in_valid = 1'b1;
    #1;
    total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL toggle_rk_idx_0 got=%0d want=0", rk_idx); end
    tick;
    for (int i = 1; i <= 10; i++) begin
      total++;
      if (rk_idx !== 4'(i) || busy !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL toggle_round_%0d got rk_idx=%0d busy=%b in_ready=%b want %0d,1,0", i, rk_idx, busy, in_ready, i);
      end
      in_valid = i[0];
      pt = {$urandom, $urandom, $urandom, $urandom};
      tick;
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || ct !== CT_C || rk_idx !== 4'd0) begin
      bad++; $display("FAIL toggle_result got out_valid=%b ct=%h rk_idx=%0d want 1,%h,0", out_valid, ct, rk_idx, CT_C);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd0) begin
      bad++; $display("FAIL toggle_no_extra got out_valid=%b busy=%b rk_idx=%0d want 0,0,0", out_valid, busy, rk_idx);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    key_sel = 1'b0; pt = PT_B; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    total++; if (rk_idx !== 4'd5) begin bad++; $display("FAIL mid_round_idx got=%0d want=5", rk_idx); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || ct !== 128'h0 || rk_idx !== 4'd0) begin
      bad++; $display("FAIL mid_reset got busy=%b out_valid=%b ct=%h rk_idx=%0d want 0,0,0,0", busy, out_valid, ct, rk_idx);
    end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_hold got=%b want=0", out_valid); end
    #3 rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready got=%b want=1", in_ready); end
    run_block(1'b0, PT_B, lat);
    total++; if (lat != 10 || ct !== CT_B) begin
      bad++; $display("FAIL mid_reset_next got lat=%0d ct=%h want 10,%h", lat, ct, CT_B);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  initial begin
    build_sbox;
    expand(KEY_B, 0);
    expand(KEY_C, 1);
    test_reset;
    test_app_b;
    test_app_c;
    test_backpressure;
    test_back_to_back;
    test_in_valid_toggle;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
